// File: rtl/dm_pkg.sv
// Shared types and defaults for the data memory controller: access size
// encodings, controller state and the default fault return value.
package dm_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [31:0] DEF_ERR_CODE = 32'hDEAD;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the MEM stage (master) and the data
// memory controller (slave), including the sticky error side-band.
interface data_mem_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        err_sticky;
    logic        err_clr;
    logic        init_done;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, err_clr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, err_sticky, init_done
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, err_clr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, err_sticky, init_done
    );

endinterface

// File: rtl/dm_lane_align.sv
// Byte-lane steering: builds byte enables and a replicated write word for
// stores, and extracts plus sign/zero-extends the addressed lane for loads.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o
);

    logic [15:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        be_o    = '0;
        wword_o = wdata_i;
        rdata_o = rword_i;
        shifted = 16'(rword_i >> {lane_i, 3'b000});
        byte_s  = signed'(shifted[7:0]);
        half_s  = signed'(shifted);
        case (size_e'(size_i))
            SZ_BYTE: begin
                be_o    = 4'b0001 << lane_i;
                wword_o = {4{wdata_i[7:0]}};
                rdata_o = unsigned_i ? {24'h0, shifted[7:0]} : 32'(byte_s);
            end
            SZ_HALF: begin
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
                rdata_o = unsigned_i ? {16'h0, shifted} : 32'(half_s);
            end
            SZ_WORD: be_o = 4'b1111;
            default: be_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: post-reset clear, byte/half/word access with
// bounds/alignment faults and a two-register response pipeline.
module data_mem_ctrl
    import dm_pkg::*;
#(
    parameter int          DEPTH          = 256,
    parameter logic [31:0] ERR_CODE       = DEF_ERR_CODE,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input logic            clk,
    input logic            rst,
    data_mem_ctrl_if.slave bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e             state_q;
    logic [IDX_W-1:0]   clr_cnt_q;
    logic               ready_q;
    logic               vld_p1_q, err_p1_q;
    logic [31:0]        rdata_p1_q, rdata_p1_d;
    logic               rsp_valid_q, rsp_err_q, err_sticky_q;
    logic [31:0]        rsp_rdata_q;
    logic [31:0]        mem_q [DEPTH];

    logic               accept, fault, misalign, out_of_range;
    logic [IDX_W-1:0]   idx;
    logic [3:0]         be;
    logic [31:0]        wword, ld_data;

    assign accept       = bus.req_valid & ready_q;
    assign idx          = bus.req_addr[IDX_W+1:2];
    // Any set upper address bit lands here as an out-of-range word index.
    assign out_of_range = bus.req_addr[31:2] >= 30'(DEPTH);

    always_comb begin
        case (size_e'(bus.req_size))
            SZ_BYTE: misalign = 1'b0;
            SZ_HALF: misalign = bus.req_addr[0];
            SZ_WORD: misalign = |bus.req_addr[1:0];
            default: misalign = 1'b1;
        endcase
    end

    assign fault = misalign | out_of_range;

    dm_lane_align u_align (
        .size_i     (bus.req_size),
        .lane_i     (bus.req_addr[1:0]),
        .unsigned_i (bus.req_unsigned),
        .wdata_i    (bus.req_wdata),
        .rword_i    (mem_q[idx]),
        .be_o       (be),
        .wword_o    (wword),
        .rdata_o    (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    clr_cnt_q <= clr_cnt_q + IDX_W'(1);
                    if (!CLEAR_ON_RESET || clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    // Storage has no reset; only the INIT sweep zeroes it.
    always_ff @(posedge clk) begin
        if (state_q == INIT && CLEAR_ON_RESET) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (accept && bus.req_write && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    always_comb begin
        rdata_p1_d = '0;
        if (accept) begin
            if (fault)               rdata_p1_d = ERR_CODE;
            else if (!bus.req_write) rdata_p1_d = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        rdata_p1_q <= rdata_p1_d;
    end

    // Accept edge fills stage 1; the following edge presents the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q     <= 1'b0;
            err_p1_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            vld_p1_q     <= accept;
            err_p1_q     <= accept & fault;
            rsp_valid_q  <= vld_p1_q;
            rsp_err_q    <= vld_p1_q & err_p1_q;
            rsp_rdata_q  <= vld_p1_q ? rdata_p1_q : 32'h0;
            err_sticky_q <= (accept & fault) | (err_sticky_q & ~bus.err_clr);
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.init_done  = ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl (DEPTH=16): directed scenarios plus randomized
// traffic against a byte-array reference model.
module tb_data_mem_ctrl;
    import dm_pkg::*;

    localparam int          DEPTH = 16;
    localparam logic [31:0] ERR   = 32'hDEAD;

    logic clk = 1'b0;
    logic rst = 1'b0;

    data_mem_ctrl_if bus ();

    data_mem_ctrl #(.DEPTH(DEPTH), .ERR_CODE(ERR), .CLEAR_ON_RESET(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] mbytes [4*DEPTH];
    bit         model_sticky = 1'b0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic set_req(input bit v, input bit wr, input logic [1:0] sz, input bit uns,
                           input logic [31:0] a, input logic [31:0] wd, input bit clr);
        bus.req_valid    = v;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.err_clr      = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 4*DEPTH; i++) mbytes[i] = 8'h00;
        model_sticky = 1'b0;
    endfunction

    // Reference behaviour: byte-addressed little-endian memory.
    function automatic void model_access(input bit wr, input logic [1:0] sz, input bit uns,
                                         input logic [31:0] a, input logic [31:0] wd,
                                         output bit err, output logic [31:0] rd);
        int n;
        longint unsigned val;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err = (sz == 2'd3) || ((a % n) != 0) || ((a / 4) >= DEPTH);
        rd  = 32'h0;
        if (err) begin
            rd = ERR;
        end else if (wr) begin
            for (int i = 0; i < n; i++) mbytes[a + i] = wd[8*i +: 8];
        end else begin
            val = 0;
            for (int i = 0; i < n; i++) val = val | (longint'(mbytes[a + i]) << (8*i));
            if (!uns && n < 4 && val[8*n-1]) val = val | ~((64'd1 << (8*n)) - 1);
            rd = val[31:0];
        end
    endfunction

    task automatic xact(input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic ov, output logic oe, output logic [31:0] od,
                        output bit ee, output logic [31:0] ed);
        set_req(1'b1, wr, sz, uns, a, wd, 1'b0);
        model_access(wr, sz, uns, a, wd, ee, ed);
        if (ee) model_sticky = 1'b1;
        step();
        set_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        ov = bus.rsp_valid;
        oe = bus.rsp_err;
        od = bus.rsp_rdata;
    endtask

    task automatic test_reset();
        set_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2 rst = 1'b1;
        step();
        step();
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.err_sticky, bus.init_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.err_sticky, bus.init_done});
        end
        checks++;
        if (bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 00000000", bus.rsp_rdata);
        end
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            step();
            checks++;
            if (bus.req_ready !== (i == DEPTH) || bus.init_done !== (i == DEPTH)) begin
                errors++;
                $display("FAIL clear_ready edge %0d: got ready=%b done=%b expected %b",
                         i, bus.req_ready, bus.init_done, (i == DEPTH));
            end
        end
        model_clear();
    endtask

    task automatic test_clear_loads();
        logic ov, oe; logic [31:0] od, ed; bit ee;
        for (int a = 0; a < 4*DEPTH; a += 4) begin
            xact(1'b0, SZ_WORD, 1'b0, 32'(a), 32'h0, ov, oe, od, ee, ed);
            checks++;
            if (ov !== 1'b1 || oe !== 1'b0 || od !== 32'h0) begin
                errors++;
                $display("FAIL clear_load @%h: got v=%b e=%b d=%h expected v=1 e=0 d=00000000",
                         a, ov, oe, od);
            end
        end
    endtask

    task automatic test_store_load_ext();
        logic ov, oe; logic [31:0] od, ed; bit ee;
        logic [1:0]  szs [3] = '{SZ_BYTE, SZ_BYTE, SZ_HALF};
        bit          unss [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] exps [3] = '{32'hFFFFFF99, 32'h00000099, 32'hFFFF8899};
        xact(1'b1, SZ_WORD, 1'b0, 32'h8, 32'h8899AABB, ov, oe, od, ee, ed);
        checks++;
        if (ov !== 1'b1 || oe !== 1'b0 || od !== 32'h0) begin
            errors++;
            $display("FAIL store_rsp: got v=%b e=%b d=%h expected v=1 e=0 d=00000000", ov, oe, od);
        end
        for (int i = 0; i < 3; i++) begin
            xact(1'b0, szs[i], unss[i], 32'hA, 32'h0, ov, oe, od, ee, ed);
            checks++;
            if (ov !== 1'b1 || oe !== 1'b0 || od !== exps[i]) begin
                errors++;
                $display("FAIL ext_load %0d: got v=%b e=%b d=%h expected v=1 e=0 d=%h",
                         i, ov, oe, od, exps[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ee; logic [31:0] ed;
        set_req(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h9, 32'h0000005A, 1'b0);
        model_access(1'b1, SZ_BYTE, 1'b0, 32'h9, 32'h5A, ee, ed);
        step();
        set_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 1'b0);
        model_access(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, ee, ed);
        step();
        set_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL b2b_store_rsp: got v=%b d=%h expected v=1 d=00000000",
                     bus.rsp_valid, bus.rsp_rdata);
        end
        step();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h88995ABB) begin
            errors++;
            $display("FAIL b2b_merge_load: got v=%b e=%b d=%h expected v=1 e=0 d=88995abb",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        step();
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_pulse_width: got v=%b expected v=0", bus.rsp_valid);
        end
    endtask

    task automatic test_faults();
        logic ov, oe; logic [31:0] od, ed; bit ee;
        xact(1'b0, SZ_HALF, 1'b0, 32'h3, 32'h0, ov, oe, od, ee, ed);
        checks++;
        if (ov !== 1'b1 || oe !== 1'b1 || od !== 32'hDEAD || bus.err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL half_misalign: got v=%b e=%b d=%h s=%b expected v=1 e=1 d=0000dead s=1",
                     ov, oe, od, bus.err_sticky);
        end
        xact(1'b1, SZ_WORD, 1'b0, 32'h40, 32'h12345678, ov, oe, od, ee, ed);
        checks++;
        if (ov !== 1'b1 || oe !== 1'b1) begin
            errors++;
            $display("FAIL oob_store: got v=%b e=%b expected v=1 e=1", ov, oe);
        end
        xact(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, ov, oe, od, ee, ed);
        checks++;
        if (oe !== 1'b1 || od !== 32'hDEAD) begin
            errors++;
            $display("FAIL oob_load: got e=%b d=%h expected e=1 d=0000dead", oe, od);
        end
        xact(1'b0, SZ_RSVD, 1'b0, 32'h0, 32'h0, ov, oe, od, ee, ed);
        checks++;
        if (oe !== 1'b1 || od !== 32'hDEAD) begin
            errors++;
            $display("FAIL rsvd_size: got e=%b d=%h expected e=1 d=0000dead", oe, od);
        end
        xact(1'b1, SZ_BYTE, 1'b0, 32'h80000008, 32'hFF, ov, oe, od, ee, ed);
        checks++;
        if (oe !== 1'b1) begin
            errors++;
            $display("FAIL high_addr_store: got e=%b expected e=1", oe);
        end
        for (int a = 0; a < 4*DEPTH; a += 4) begin
            xact(1'b0, SZ_WORD, 1'b0, 32'(a), 32'h0, ov, oe, od, ee, ed);
            checks++;
            if (oe !== 1'b0 || od !== ed) begin
                errors++;
                $display("FAIL fault_unchanged @%h: got e=%b d=%h expected e=0 d=%h", a, oe, od, ed);
            end
        end
    endtask

    task automatic test_err_clr();
        set_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h2, 32'h0, 1'b1);
        step();
        checks++;
        if (bus.err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_set: got s=%b expected s=1", bus.err_sticky);
        end
        set_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1);
        step();
        checks++;
        if (bus.err_sticky !== 1'b0 || bus.rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL clr_alone: got s=%b e=%b expected s=0 e=1", bus.err_sticky, bus.rsp_err);
        end
        set_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        model_sticky = 1'b0;
        checks++;
        if (bus.err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL clr_hold: got s=%b expected s=0", bus.err_sticky);
        end
    endtask

    task automatic test_random();
        bit v, wr, uns, clr, ce;
        logic [1:0] sz;
        logic [31:0] a, wd, crd;
        bit p1v = 0, p1e = 0, p2v = 0, p2e = 0;
        logic [31:0] p1d = 0, p2d = 0;
        for (int k = 0; k < 320; k++) begin
            v   = (k < 300) && ($urandom_range(0, 4) != 0);
            wr  = $urandom_range(0, 1);
            sz  = 2'($urandom_range(0, 3));
            uns = $urandom_range(0, 1);
            a   = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH + 7));
            if ($urandom_range(0, 1)) a = a & ~32'h3;
            wd  = $urandom;
            clr = ($urandom_range(0, 9) == 0);
            set_req(v, wr, sz, uns, a, wd, clr);
            ce  = 1'b0;
            crd = 32'h0;
            if (v) model_access(wr, sz, uns, a, wd, ce, crd);
            model_sticky = (v && ce) ? 1'b1 : (clr ? 1'b0 : model_sticky);
            step();
            p2v = p1v; p2e = p1e; p2d = p1d;
            p1v = v;   p1e = ce;  p1d = crd;
            checks++;
            if (bus.rsp_valid !== p2v || bus.rsp_err !== (p2v & p2e) ||
                bus.rsp_rdata !== (p2v ? p2d : 32'h0)) begin
                errors++;
                $display("FAIL random_rsp cycle %0d: got v=%b e=%b d=%h expected v=%b e=%b d=%h",
                         k, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, p2v, p2v & p2e,
                         p2v ? p2d : 32'h0);
            end
            checks++;
            if (bus.err_sticky !== model_sticky) begin
                errors++;
                $display("FAIL random_sticky cycle %0d: got %b expected %b",
                         k, bus.err_sticky, model_sticky);
            end
        end
        set_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_midflight();
        logic ov, oe; logic [31:0] od, ed; bit ee;
        set_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 1'b0);
        step();
        set_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 1'b0);
        step();
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_rsp: got v=%b expected v=1", bus.rsp_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got v=%b r=%b expected v=0 r=0", bus.rsp_valid, bus.req_ready);
        end
        set_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        step();
        rst = 1'b0;
        model_clear();
        for (int i = 1; i <= DEPTH; i++) begin
            step();
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.req_ready !== (i == DEPTH)) begin
                errors++;
                $display("FAIL reclear edge %0d: got v=%b r=%b expected v=0 r=%b",
                         i, bus.rsp_valid, bus.req_ready, (i == DEPTH));
            end
        end
        xact(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, ov, oe, od, ee, ed);
        checks++;
        if (ov !== 1'b1 || oe !== 1'b0 || od !== 32'h0 || bus.err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_load: got v=%b e=%b d=%h s=%b expected v=1 e=0 d=00000000 s=0",
                     ov, oe, od, bus.err_sticky);
        end
    endtask

    initial begin
        test_reset();
        test_clear_loads();
        test_store_load_ext();
        test_back_to_back();
        test_faults();
        test_err_clr();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
